// File: rtl/uart_rx_mv_pkg.sv
// Shared types and helpers for the UART receive path: FSM state codes,
// the 3-sample majority vote and the data parity reduction.
package uart_rx_mv_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_rx_mv_sync.sv
// rx synchroniser chain plus one extra history flop used to spot the
// falling edge of the synchronised line.
module uart_rx_mv_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   rx_prev_q;

    // Synchroniser and edge history; idle-high line, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q   <= {SYNC_STAGES{1'b1}};
            rx_prev_q <= 1'b1;
        end else begin
            chain_q   <= {chain_q[SYNC_STAGES-2:0], rx_i};
            rx_prev_q <= chain_q[SYNC_STAGES-1];
        end
    end

    assign rx_s_o = chain_q[SYNC_STAGES-1];
    assign fall_o = ~chain_q[SYNC_STAGES-1] & rx_prev_q;

endmodule

// File: rtl/uart_rx_mv.sv
// UART receiver, 8N1 with optional parity: majority-voted bit-centre
// sampling, held byte with acknowledge, framing/parity/overrun flags.
module uart_rx_mv
    import uart_rx_mv_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx,
    input  logic [15:0]          baud_div,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s, fall_s, vote_s, par_calc_s;
    logic [15:0] half_s, hm1_s, hp1_s, last_s;
    logic [7:0]  shreg_ext_s;

    rx_state_t            state_q, state_d;
    logic [15:0]          cyc_q, cyc_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
    logic s0_q, s0_d, s1_q, s1_d, perr_q, perr_d;
    logic valid_q, valid_d, done_q, done_d, ferr_q, ferr_d;
    logic perr_out_q, perr_out_d, ovr_q, ovr_d;

    uart_rx_mv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (fall_s)
    );

    assign half_s      = baud_div >> 1;
    assign hm1_s       = half_s - 16'd1;
    assign hp1_s       = half_s + 16'd1;
    assign last_s      = baud_div - 16'd1;
    assign vote_s      = majority3(s0_q, s1_q, rx_s);
    assign shreg_ext_s = 8'(shreg_q);
    assign par_calc_s  = parity8(shreg_ext_s) ^ 1'(PARITY_ODD);

    // Next-state logic for the frame FSM, sampler and output holding registers.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        ferr_d     = ferr_q;
        perr_out_d = perr_out_q;

        if (cyc_q == hm1_s) s0_d = rx_s; else s0_d = s0_q;
        if (cyc_q == half_s) s1_d = rx_s; else s1_d = s1_q;

        if (rd_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
            ovr_d   = ovr_q;
        end

        if (!en) begin
            state_d = ST_IDLE;
            cyc_d   = 16'd0;
            bit_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_d = ST_START;
                        cyc_d   = 16'd0;
                    end else begin
                        cyc_d = 16'd0;
                    end
                end
                ST_START: begin
                    if ((cyc_q == hp1_s) && vote_s) begin
                        state_d = ST_IDLE;
                        cyc_d   = 16'd0;
                    end else if (cyc_q == last_s) begin
                        state_d = ST_DATA;
                        cyc_d   = 16'd0;
                        bit_d   = 3'd0;
                        perr_d  = 1'b0;
                    end else begin
                        cyc_d = cyc_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cyc_q == hp1_s) begin
                        shreg_d = {vote_s, shreg_q[DATA_BITS-1:1]};
                    end else begin
                        shreg_d = shreg_q;
                    end
                    if (cyc_q == last_s) begin
                        cyc_d = 16'd0;
                        if (bit_q == LAST_BIT) begin
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            bit_d   = 3'd0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + 16'd1;
                    end
                end
                ST_PARITY: begin
                    if (cyc_q == hp1_s) begin
                        perr_d = par_calc_s ^ vote_s;
                    end else begin
                        perr_d = perr_q;
                    end
                    if (cyc_q == last_s) begin
                        state_d = ST_STOP;
                        cyc_d   = 16'd0;
                    end else begin
                        cyc_d = cyc_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    // Complete at the stop-bit centre so a back-to-back start edge is not missed.
                    if (cyc_q == hp1_s) begin
                        state_d    = ST_IDLE;
                        cyc_d      = 16'd0;
                        done_d     = 1'b1;
                        data_d     = shreg_q;
                        ferr_d     = ~vote_s;
                        perr_out_d = perr_q;
                        valid_d    = 1'b1;
                        ovr_d      = ovr_q | (valid_q & ~rd_ack);
                    end else begin
                        cyc_d = cyc_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cyc_d   = 16'd0;
                    bit_d   = 3'd0;
                end
            endcase
        end
    end

    // State, counters and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 16'd0;
            bit_q      <= 3'd0;
            shreg_q    <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            perr_out_q <= perr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign done       = done_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_out_q;
    assign overrun    = ovr_q;

endmodule
